sevenseg_scan_decoder: RTL

Receive side of the multiplexed seven-segment display bus driven by `top`. Samples the active-low `anode`/`cathode` scan, debounces each digit slot against scan ghosting, and decodes segment patterns back to hex nibbles. Assembles a full frame in a shadow buffer and publishes it atomically. Used as an on-chip loopback monitor and as the display checker in stopwatch testbenches.

---
 rtl/sevenseg_pkg.sv | 49 ++++
 rtl/sevenseg_pattern_decode.sv | 50 +++++
 rtl/sevenseg_scan_decoder.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sevenseg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sevenseg_pkg
//  Description : Shared definitions for the seven-segment scan receiver.
//                Holds the active-high segment patterns (g..a) for the hex
//                digits and the blank pattern, the bit positions of each
//                segment in the cathode bus, and the frame FSM encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package sevenseg_pkg;

    // Active-high segment patterns, bit 6 = g ... bit 0 = a
    localparam logic [6:0] c_seg_0     = 7'h3F;
    localparam logic [6:0] c_seg_1     = 7'h06;
    localparam logic [6:0] c_seg_2     = 7'h5B;
    localparam logic [6:0] c_seg_3     = 7'h4F;
    localparam logic [6:0] c_seg_4     = 7'h66;
    localparam logic [6:0] c_seg_5     = 7'h6D;
    localparam logic [6:0] c_seg_6     = 7'h7D;
    localparam logic [6:0] c_seg_7     = 7'h07;
    localparam logic [6:0] c_seg_8     = 7'h7F;
    localparam logic [6:0] c_seg_9     = 7'h6F;
    localparam logic [6:0] c_seg_a     = 7'h77;
    localparam logic [6:0] c_seg_b     = 7'h7C;
    localparam logic [6:0] c_seg_c     = 7'h39;
    localparam logic [6:0] c_seg_d     = 7'h5E;
    localparam logic [6:0] c_seg_e     = 7'h79;
    localparam logic [6:0] c_seg_f     = 7'h71;
    localparam logic [6:0] c_seg_blank = 7'h00;

    // Bit positions on the cathode bus
    localparam int c_bit_ca = 0;
    localparam int c_bit_cb = 1;
    localparam int c_bit_cc = 2;
    localparam int c_bit_cd = 3;
    localparam int c_bit_ce = 4;
    localparam int c_bit_cf = 5;
    localparam int c_bit_cg = 6;
    localparam int c_bit_dp = 7;

    // Frame assembly FSM
    typedef enum logic [1:0] {
        st_idle  = 2'd0,
        st_scan  = 2'd1,
        st_stale = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/sevenseg_pattern_decode.sv
`default_nettype none
// ============================================================================
//  Module      : sevenseg_pattern_decode
//  Description : Combinational decode of an active-high 7-segment pattern
//                (g..a) to a hex nibble. The all-off pattern reports blank
//                with nibble 0; any unknown pattern reports invalid with
//                nibble 0.
//  Ports       : pattern [6:0] in  - active-high segments, bit 0 = a
//                nibble  [3:0] out - decoded hex value
//                blank         out - no segment lit
//                invalid       out - pattern is not a hex digit or blank
//  Revision    : 1.0 - initial release
// ============================================================================
module sevenseg_pattern_decode
    import sevenseg_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] nibble,
    output logic       blank,
    output logic       invalid
);

    always_comb begin
        nibble  = 4'h0;
        blank   = 1'b0;
        invalid = 1'b0;
        case (pattern)
            c_seg_0:     nibble = 4'h0;
            c_seg_1:     nibble = 4'h1;
            c_seg_2:     nibble = 4'h2;
            c_seg_3:     nibble = 4'h3;
            c_seg_4:     nibble = 4'h4;
            c_seg_5:     nibble = 4'h5;
            c_seg_6:     nibble = 4'h6;
            c_seg_7:     nibble = 4'h7;
            c_seg_8:     nibble = 4'h8;
            c_seg_9:     nibble = 4'h9;
            c_seg_a:     nibble = 4'hA;
            c_seg_b:     nibble = 4'hB;
            c_seg_c:     nibble = 4'hC;
            c_seg_d:     nibble = 4'hD;
            c_seg_e:     nibble = 4'hE;
            c_seg_f:     nibble = 4'hF;
            c_seg_blank: blank  = 1'b1;
            default:     invalid = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/sevenseg_scan_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : sevenseg_scan_decoder
//  Description : Receiver for a multiplexed, active-low seven-segment scan.
//                Debounces each anode/cathode pair, decodes captured digits
//                into a shadow frame buffer and publishes a complete frame
//                atomically once every slot has been seen after slot 0.
//  Ports       : clock, reset (async, active-low)
//                anode   [NUM_DIGITS-1:0] in  - active-low digit enables
//                cathode [7:0]            in  - active-low segments + DP
//                digits  [4*NUM_DIGITS-1:0] out - nibble per slot
//                dp / blank [NUM_DIGITS-1:0] out - per-slot flags
//                frame_done out - one-cycle publish pulse
//                frame_count [15:0] out - published frames, wrapping
//                seg_error out - sticky bad pattern / bad anode flag
//                stale out - no capture for TIMEOUT cycles
//  Revision    : 1.0 - initial release
// ============================================================================
module sevenseg_scan_decoder
    import sevenseg_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int SETTLE     = 4,
    parameter int TIMEOUT    = 2_000_000
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NUM_DIGITS-1:0]   anode,
    input  logic [7:0]              cathode,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic [NUM_DIGITS-1:0]   dp,
    output logic [NUM_DIGITS-1:0]   blank,
    output logic                    frame_done,
    output logic [15:0]             frame_count,
    output logic                    seg_error,
    output logic                    stale
);

    localparam int c_settle_w = $clog2(SETTLE + 1);
    localparam int c_tmo_w    = $clog2(TIMEOUT + 1);
    localparam logic [c_settle_w-1:0] c_settle_max  = c_settle_w'(SETTLE);
    localparam logic [c_settle_w-1:0] c_settle_last = c_settle_w'(SETTLE - 1);
    localparam logic [c_tmo_w-1:0]    c_tmo_max     = c_tmo_w'(TIMEOUT);

    // ------------------------------------------------------------------
    // Input registers and settle counter
    // ------------------------------------------------------------------
    logic [NUM_DIGITS-1:0] r_anode;
    logic [NUM_DIGITS-1:0] r_anode_prev;
    logic [7:0]            r_cathode;
    logic [7:0]            r_cathode_prev;
    logic [c_settle_w-1:0] r_settle;
    logic                  w_same;
    logic                  w_fire;

    assign w_same = (r_anode == r_anode_prev) && (r_cathode == r_cathode_prev);
    // Fires exactly once per stable pair: the count passes through
    // SETTLE-1 only once before it saturates at SETTLE.
    assign w_fire = w_same && (r_settle == c_settle_last);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_anode        <= '1;
            r_anode_prev   <= '1;
            r_cathode      <= '1;
            r_cathode_prev <= '1;
            r_settle       <= '0;
        end else begin
            r_anode        <= anode;
            r_cathode      <= cathode;
            r_anode_prev   <= r_anode;
            r_cathode_prev <= r_cathode;
            if (!w_same) begin
                r_settle <= '0;
            end else if (r_settle != c_settle_max) begin
                r_settle <= r_settle + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Capture classification and decode
    // ------------------------------------------------------------------
    logic [NUM_DIGITS-1:0] w_low;
    logic                  w_gap;
    logic                  w_multi;
    logic                  w_cap;
    logic                  w_slot0;
    logic [6:0]            w_pattern;
    logic [3:0]            w_nibble;
    logic                  w_blank;
    logic                  w_invalid;
    logic                  w_dp;

    assign w_low   = ~r_anode;
    assign w_gap   = ~|w_low;
    // More than one bit set: clearing the lowest set bit leaves something
    assign w_multi = |(w_low & (w_low - 1'b1));
    assign w_cap   = w_fire && !w_gap && !w_multi;
    assign w_slot0 = w_low[0];

    assign w_pattern = ~{r_cathode[c_bit_cg], r_cathode[c_bit_cf], r_cathode[c_bit_ce],
                         r_cathode[c_bit_cd], r_cathode[c_bit_cc], r_cathode[c_bit_cb],
                         r_cathode[c_bit_ca]};
    assign w_dp      = ~r_cathode[c_bit_dp];

    sevenseg_pattern_decode u_decode (
        .pattern (w_pattern),
        .nibble  (w_nibble),
        .blank   (w_blank),
        .invalid (w_invalid)
    );

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    state_t                r_state;
    state_t                w_state_next;
    logic [NUM_DIGITS-1:0] r_seen;
    logic [NUM_DIGITS-1:0] w_seen_next;
    logic [c_tmo_w-1:0]    r_tmo;
    logic                  w_accept;
    logic                  w_restart;
    logic                  w_publish;

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_restart    = 1'b0;
        w_publish    = 1'b0;
        case (r_state)
            st_idle, st_stale: begin
                if (w_cap && w_slot0) begin
                    w_accept     = 1'b1;
                    w_restart    = 1'b1;
                    w_state_next = st_scan;
                end
            end
            st_scan: begin
                w_publish = &r_seen;
                if (w_cap) begin
                    w_accept  = 1'b1;
                    w_restart = w_slot0;
                end else if (r_tmo == c_tmo_max) begin
                    w_state_next = st_stale;
                end
            end
            default: w_state_next = st_idle;
        endcase
    end

    // Publish (if any) clears seen before the current capture is marked,
    // so a slot-0 capture on a publish cycle starts the next frame.
    always_comb begin
        w_seen_next = r_seen;
        if (w_publish || w_restart) begin
            w_seen_next = '0;
        end
        if (w_accept) begin
            w_seen_next = w_seen_next | w_low;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= st_idle;
            r_seen  <= '0;
            r_tmo   <= '0;
        end else begin
            r_state <= w_state_next;
            r_seen  <= w_seen_next;
            if (w_cap) begin
                r_tmo <= '0;
            end else if (r_tmo != c_tmo_max) begin
                r_tmo <= r_tmo + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Shadow buffer and published outputs
    // ------------------------------------------------------------------
    logic [4*NUM_DIGITS-1:0] r_sh_digits;
    logic [NUM_DIGITS-1:0]   r_sh_dp;
    logic [NUM_DIGITS-1:0]   r_sh_blank;
    logic [4*NUM_DIGITS-1:0] r_digits;
    logic [NUM_DIGITS-1:0]   r_dp;
    logic [NUM_DIGITS-1:0]   r_blank;
    logic                    r_frame_done;
    logic [15:0]             r_frame_count;
    logic                    r_seg_error;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sh_digits <= '0;
            r_sh_dp     <= '0;
            r_sh_blank  <= '1;
        end else if (w_accept) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (w_low[i]) begin
                    r_sh_digits[4*i +: 4] <= w_nibble;
                    r_sh_dp[i]            <= w_dp;
                    r_sh_blank[i]         <= w_blank;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_digits      <= '0;
            r_dp          <= '0;
            r_blank       <= '1;
            r_frame_done  <= 1'b0;
            r_frame_count <= '0;
            r_seg_error   <= 1'b0;
        end else begin
            r_frame_done <= w_publish;
            if (w_publish) begin
                r_digits      <= r_sh_digits;
                r_dp          <= r_sh_dp;
                r_blank       <= r_sh_blank;
                r_frame_count <= r_frame_count + 16'd1;
            end
            if ((w_fire && w_multi) || (w_cap && w_invalid)) begin
                r_seg_error <= 1'b1;
            end
        end
    end

    assign digits      = r_digits;
    assign dp          = r_dp;
    assign blank       = r_blank;
    assign frame_done  = r_frame_done;
    assign frame_count = r_frame_count;
    assign seg_error   = r_seg_error;
    assign stale       = (r_state == st_stale);

endmodule
`default_nettype wire
